pipeline_halt_monitor: RTL

PIPELINE_HALT_MONITOR -- requirements
Module: pipeline_halt_monitor

---
 rtl/pipeline_monitor_pkg.sv | 14 +
 rtl/trace_fifo.sv | 78 +++++++
 rtl/pipeline_halt_monitor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipeline_monitor_pkg.sv
// Shared types and constants for the pipeline halt monitor.
// The monitor state encoding is visible on state_o, so its values are fixed here.
package pipeline_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } monitor_state_t;

    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_0001;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead trace FIFO for retired instructions, with a sticky overflow flag.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module trace_fifo #(
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  logic [XLEN-1:0]                push_data_i,
    input  logic                           pop_i,
    output logic [XLEN-1:0]                head_o,
    output logic                           empty_o,
    output logic [$clog2(TRACE_DEPTH):0]   count_o,
    output logic                           overflow_o
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    assign full    = (count_q == CNT_W'(TRACE_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign drop    = push_i && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign head_o     = mem[rd_ptr];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pipeline_halt_monitor.sv
// Watches one pipeline stage for a halt sentinel, drains for a fixed number of
// cycles, then reports halted; counts cycles/retires and traces retired instructions.
module pipeline_halt_monitor
    import pipeline_monitor_pkg::*;
#(
    parameter int              NUM_STAGES   = 5,
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] HALT_INSTR   = XLEN'(DEFAULT_HALT_INSTR),
    parameter int              DRAIN_CYCLES = 10,
    parameter int              TRACE_DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_STAGES*XLEN-1:0]      instr_i,
    input  logic [NUM_STAGES-1:0]           stage_valid_i,
    input  logic [$clog2(NUM_STAGES)-1:0]   halt_sel_i,
    input  logic                            enable_i,
    input  logic                            clear_i,
    input  logic                            trace_rd_i,
    output logic [XLEN-1:0]                 trace_data_o,
    output logic                            trace_empty_o,
    output logic [$clog2(TRACE_DEPTH):0]    trace_count_o,
    output logic [31:0]                     cycle_count_o,
    output logic [31:0]                     retired_count_o,
    output logic                            halted_o,
    output logic                            overflow_o,
    output logic [1:0]                      state_o
);

    localparam int SEL_W   = $clog2(NUM_STAGES);
    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    monitor_state_t     state_q;
    monitor_state_t     state_d;
    logic [DRAIN_W-1:0] drain_q;
    logic [XLEN-1:0]    watched_instr;
    logic               watched_valid;
    logic               halt_hit;
    logic               active;
    logic               retire;
    logic [31:0]        cycle_q;
    logic [31:0]        retired_q;

    // Select values beyond the last stage match nothing.
    always_comb begin
        watched_instr = '0;
        watched_valid = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (halt_sel_i == SEL_W'(k)) begin
                watched_instr = instr_i[k*XLEN +: XLEN];
                watched_valid = stage_valid_i[k];
            end
        end
    end

    assign halt_hit = watched_valid && (watched_instr == HALT_INSTR);
    assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign retire   = active && stage_valid_i[NUM_STAGES-1] && !clear_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_hit) begin
                        state_d = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q <= DRAIN_W'(1)) begin
                        state_d = ST_HALTED;
                    end
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // The drain counter holds the number of DRAIN cycles still to go.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_q <= '0;
        end else if (clear_i) begin
            drain_q <= '0;
        end else if (state_q == ST_RUN && halt_hit) begin
            drain_q <= DRAIN_W'(DRAIN_CYCLES);
        end else if (state_q == ST_DRAIN && drain_q != '0) begin
            drain_q <= drain_q - DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else if (clear_i) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (active && cycle_q != 32'hFFFF_FFFF) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (retire && retired_q != 32'hFFFF_FFFF) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    trace_fifo #(
        .XLEN        (XLEN),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear_i),
        .push_i      (retire),
        .push_data_i (instr_i[(NUM_STAGES-1)*XLEN +: XLEN]),
        .pop_i       (trace_rd_i),
        .head_o      (trace_data_o),
        .empty_o     (trace_empty_o),
        .count_o     (trace_count_o),
        .overflow_o  (overflow_o)
    );

    assign cycle_count_o   = cycle_q;
    assign retired_count_o = retired_q;
    assign halted_o        = (state_q == ST_HALTED);
    assign state_o         = state_q;

endmodule
